// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two buffered byte requesters sharing one uart_tx.
// Each requester feeds a small FIFO; a three-state FSM picks a non-empty
// FIFO (round-robin under contention), issues a one-cycle start strobe to
// uart_tx, then waits for the end-of-frame pulse before arbitrating again.
// Optional per-requester frame counters: define UART_TX_ARBITER_STATS_EN.

// Per-requester byte FIFO with a registered "not full" flag.
module uart_tx_arbiter_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Push_DV,
    input  logic [7:0] i_Push_Byte,
    input  logic       i_Pop,
    output logic       o_Ready,
    output logic       o_Empty,
    output logic [7:0] o_Head
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [7:0]       r_Mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_Wr_Ptr;
    logic [PTR_W-1:0] r_Rd_Ptr;
    logic [PTR_W:0]   r_Count;
    logic [PTR_W:0]   w_Count_Nxt;
    logic             r_Ready;
    logic             w_Push;
    logic             w_Pop;

    // A strobe arriving while full is simply ignored; pop of an empty FIFO too.
    assign w_Push  = i_Push_DV & r_Ready;
    assign w_Pop   = i_Pop & (r_Count != '0);
    assign o_Ready = r_Ready;
    assign o_Empty = (r_Count == '0);
    assign o_Head  = r_Mem[r_Rd_Ptr];

    // Occupancy after this cycle's push/pop; simultaneous push+pop cancels.
    always_comb begin
        w_Count_Nxt = r_Count;
        case ({w_Push, w_Pop})
            2'b10:   w_Count_Nxt = r_Count + 1'b1;
            2'b01:   w_Count_Nxt = r_Count - 1'b1;
            default: w_Count_Nxt = r_Count;
        endcase
    end

    // Pointers and count; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
            r_Ready  <= 1'b1;
        end else begin
            if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            r_Count <= w_Count_Nxt;
            r_Ready <= (w_Count_Nxt < DEPTH_C);
        end
    end

    // Storage array; contents need no reset since the count gates reads.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && w_Push) r_Mem[r_Wr_Ptr] <= i_Push_Byte;
    end
endmodule

// Top level: two FIFOs, grant FSM, uart_tx handshake and optional stats.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Req0_DV,
    input  logic [7:0]  i_Req0_Byte,
    output logic        o_Req0_Ready,
    input  logic        i_Req1_DV,
    input  logic [7:0]  i_Req1_Byte,
    output logic        o_Req1_Ready,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_Grant,
    output logic        o_Busy,
    output logic [15:0] o_Req0_Count,
    output logic [15:0] o_Req1_Count
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          r_State;
    state_t          w_State_Nxt;

    logic [1:0]      w_Push_DV;
    logic [1:0][7:0] w_Push_Byte;
    logic [1:0]      w_Pop;
    logic [1:0]      w_Ready;
    logic [1:0]      w_Empty;
    logic [1:0][7:0] w_Head;

    logic            r_Tx_DV;
    logic [7:0]      r_Tx_Byte;
    logic            r_Grant;
    logic            r_Last_Grant;
    logic            w_Tx_DV_Nxt;
    logic [7:0]      w_Tx_Byte_Nxt;
    logic            w_Grant_Nxt;
    logic            w_Last_Grant_Nxt;
    logic            w_Pick;

    assign w_Push_DV   = {i_Req1_DV, i_Req0_DV};
    assign w_Push_Byte = {i_Req1_Byte, i_Req0_Byte};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            uart_tx_arbiter_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
                .i_Clock     (i_Clock),
                .i_Reset     (i_Reset),
                .i_Push_DV   (w_Push_DV[g]),
                .i_Push_Byte (w_Push_Byte[g]),
                .i_Pop       (w_Pop[g]),
                .o_Ready     (w_Ready[g]),
                .o_Empty     (w_Empty[g]),
                .o_Head      (w_Head[g])
            );
        end
    endgenerate

    assign o_Req0_Ready = w_Ready[0];
    assign o_Req1_Ready = w_Ready[1];
    assign o_Tx_DV      = r_Tx_DV;
    assign o_Tx_Byte    = r_Tx_Byte;
    assign o_Grant      = r_Grant;
    assign o_Busy       = (r_State != IDLE);

    // Sole non-empty FIFO wins; under contention alternate from last grant.
    assign w_Pick = w_Empty[0] ? 1'b1 :
                    w_Empty[1] ? 1'b0 : ~r_Last_Grant;

    // Next-state, pop and registered-output next values.
    always_comb begin
        w_State_Nxt      = r_State;
        w_Pop            = 2'b00;
        w_Tx_DV_Nxt      = 1'b0;
        w_Tx_Byte_Nxt    = r_Tx_Byte;
        w_Grant_Nxt      = r_Grant;
        w_Last_Grant_Nxt = r_Last_Grant;
        case (r_State)
            IDLE: begin
                // Only start when the UART is quiet and there is data.
                if (!i_Tx_Active && !(&w_Empty)) begin
                    w_State_Nxt      = SEND;
                    w_Pop[w_Pick]    = 1'b1;
                    w_Tx_DV_Nxt      = 1'b1;
                    w_Tx_Byte_Nxt    = w_Head[w_Pick];
                    w_Grant_Nxt      = w_Pick;
                    w_Last_Grant_Nxt = w_Pick;
                end
            end
            SEND: w_State_Nxt = WAIT;
            WAIT: if (i_Tx_Done) w_State_Nxt = IDLE;
            default: w_State_Nxt = IDLE;
        endcase
    end

    // State and output registers; last-grant starts at 1 so req 0 wins first.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State      <= IDLE;
            r_Tx_DV      <= 1'b0;
            r_Tx_Byte    <= 8'h00;
            r_Grant      <= 1'b0;
            r_Last_Grant <= 1'b1;
        end else begin
            r_State      <= w_State_Nxt;
            r_Tx_DV      <= w_Tx_DV_Nxt;
            r_Tx_Byte    <= w_Tx_Byte_Nxt;
            r_Grant      <= w_Grant_Nxt;
            r_Last_Grant <= w_Last_Grant_Nxt;
        end
    end

`ifdef UART_TX_ARBITER_STATS_EN
    logic [15:0] r_Req0_Count;
    logic [15:0] r_Req1_Count;

    // Count frames granted per requester; a pop only happens on IDLE->SEND.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Req0_Count <= 16'h0000;
            r_Req1_Count <= 16'h0000;
        end else begin
            if (w_Pop[0]) r_Req0_Count <= r_Req0_Count + 16'd1;
            if (w_Pop[1]) r_Req1_Count <= r_Req1_Count + 16'd1;
        end
    end

    assign o_Req0_Count = r_Req0_Count;
    assign o_Req1_Count = r_Req1_Count;
`else
    assign o_Req0_Count = 16'h0000;
    assign o_Req1_Count = 16'h0000;
`endif
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, per-requester buffer depth in bytes; power of two, 2..16.
REQ-002 Port: i_Clock  input  1  sole clock; all logic on rising edge.
REQ-003 Port: i_Reset  input  1  synchronous, active-high reset.
REQ-004 Port: i_Req0_DV  input  1  requester 0 byte valid, one-cycle strobe per byte.
REQ-005 Port: i_Req0_Byte  input  8  requester 0 byte.
REQ-006 Port: o_Req0_Ready  output  1  requester 0 FIFO not full.
REQ-007 Port: i_Req1_DV  input  1  requester 1 byte valid.
REQ-008 Port: i_Req1_Byte  input  8  requester 1 byte.
REQ-009 Port: o_Req1_Ready  output  1  requester 1 FIFO not full.
REQ-010 Port: o_Tx_DV  output  1  one-cycle start strobe to uart_tx.
REQ-011 Port: o_Tx_Byte  output  8  byte to uart_tx; held stable from the o_Tx_DV cycle until i_Tx_Done.
REQ-012 Port: i_Tx_Active  input  1  uart_tx frame in progress.
REQ-013 Port: i_Tx_Done  input  1  uart_tx end-of-frame pulse.
REQ-014 Port: o_Grant  output  1  requester owning the current or last frame (0/1).
REQ-015 Port: o_Busy  output  1  high in SEND or WAIT.
REQ-016 Port: o_Req0_Count, o_Req1_Count  output  16 each  bytes sent per requester (see Configuration).

Function
REQ-017 Each requester SHALL have a FIFO_DEPTH-entry FIFO; a push SHALL occur on a cycle with iReqN_DV=1 and o_ReqN_Ready=1.
REQ-018 o_ReqN_Ready SHALL be registered and equal (count < FIFO_DEPTH) at the start of the cycle; a DV while Ready=0 SHALL be dropped, with no state change.
REQ-019 A push and a pop on the same FIFO in one cycle SHALL both take effect, leaving the count unchanged.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-021 The FSM SHALL have exactly three states: IDLE, SEND and WAIT.
REQ-022 IDLE->SEND SHALL occur when i_Tx_Active=0 and at least one FIFO is non-empty; on that edge the FSM SHALL pop the granted FIFO, load o_Tx_Byte, set o_Tx_DV=1 and update o_Grant.
REQ-023 Grant choice SHALL be: the only non-empty FIFO if just one is non-empty; otherwise the requester that was not last granted (round-robin).
REQ-024 SEND->WAIT SHALL occur unconditionally after one cycle, with o_Tx_DV returning to 0, so the strobe lasts exactly one cycle.
REQ-025 WAIT->IDLE SHALL occur on the edge sampling i_Tx_Done=1; i_Tx_Done in IDLE or SEND SHALL be ignored.
REQ-026 Latency: a byte pushed into an empty FIFO in cycle N, with the FSM IDLE and i_Tx_Active=0, SHALL produce o_Tx_DV=1 in cycle N+2.
REQ-027 Back-to-back frames: the minimum gap from i_Tx_Done to the next o_Tx_DV SHALL be one cycle (the IDLE cycle).
REQ-028 The FSM SHALL never issue o_Tx_DV while i_Tx_Active=1.

Reset
REQ-029 On i_Reset=1 the block SHALL enter state IDLE, empty both FIFOs and set o_Tx_DV=0, o_Tx_Byte=8'h00, o_Grant=0, o_Busy=0, o_Req0_Ready=1, o_Req1_Ready=1 and both counts to 0.
REQ-030 After reset, requester 0 SHALL win the first two-way contention (last-grant register resets to 1).
REQ-031 After a reset mid-frame, the block SHALL discard all buffered data and SHALL not start a new frame until i_Tx_Active=0.
REQ-032 i_Reset SHALL take priority over a simultaneous push or i_Tx_Done.

Configuration
REQ-033 Macro UART_TX_ARBITER_STATS_EN: when defined, o_ReqN_Count SHALL increment, with 16-bit wrap (16'hFFFF->16'h0000), on each IDLE->SEND edge granting requester N.
REQ-034 When UART_TX_ARBITER_STATS_EN is undefined, the counters SHALL not be synthesised and o_Req0_Count and o_Req1_Count SHALL be constant 0.

Verification
REQ-035 Single byte: Req0 pushes 8'hAB at cycle N with the FSM IDLE -> o_Tx_DV=1 at N+2 with o_Tx_Byte=8'hAB and o_Grant=0; i_Tx_Done returns the FSM to IDLE.
REQ-036 Contention: Req0 pushes 8'h11, 8'h22 and Req1 pushes 8'hA1, 8'hA2 while the FSM is IDLE -> frames go out in the order 11, A1, 22, A2.
REQ-037 Full FIFO: 5 Req1 pushes while WAIT is stalled -> o_Req1_Ready=0 after the 4th push; the 5th byte is dropped; 4 frames follow, in order.
REQ-038 Reset during WAIT with 3 bytes buffered -> no further o_Tx_DV while i_Tx_Active=1; both Ready=1; nothing is sent afterwards.
REQ-039 Stats: with UART_TX_ARBITER_STATS_EN defined, 3 Req0 and 2 Req1 frames -> counts 3 and 2; with the macro undefined -> both counts 0.
